// File: rtl/rle_word_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rle_pkg
//  Brief    : Shared types, code-field layout and unpack helper for the
//             RLE word packer.
//  Revision : 1.0  initial release
// ============================================================================
package rle_pkg;

   localparam int WORD_W  = 16;
   localparam int RUN_W   = 2;
   localparam int IDX_W   = 32;
   localparam int CODE_W  = RUN_W + 1;
   localparam int VAL_BIT = RUN_W;
   localparam int RUN_MSB = RUN_W - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_OUT    = 2'd2
   } state_t;

   typedef struct packed {
      logic             val;
      logic [RUN_W-1:0] run;
   } code_t;

   // Split an incoming code into its bit value and run length.
   function automatic code_t rle_unpack(input logic [CODE_W-1:0] code);
      code_t c;
      c.val = code[VAL_BIT];
      c.run = code[RUN_MSB:0];
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rle_word_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rle_word_packer_if
//  Brief    : Code-input and word-output handshake bundle of the packer.
//             master = stream source / word consumer, slave = packer.
//  Revision : 1.0  initial release
// ============================================================================
interface rle_word_packer_if #(
   parameter int WORD_W = 16,
   parameter int RUN_W  = 2,
   parameter int IDX_W  = 32
);
   logic              code_valid;
   logic              code_ready;
   logic [RUN_W:0]    code_in;
   logic              code_last;
   logic              word_valid;
   logic              word_ready;
   logic [WORD_W-1:0] word_out;
   logic [IDX_W-1:0]  word_idx;
   logic              word_last;
   logic [3:0]        bit_idx;
   logic              done;

   modport master (
      output code_valid, code_in, code_last, word_ready,
      input  code_ready, word_valid, word_out, word_idx, word_last,
             bit_idx, done
   );

   modport slave (
      input  code_valid, code_in, code_last, word_ready,
      output code_ready, word_valid, word_out, word_idx, word_last,
             bit_idx, done
   );
endinterface
`default_nettype wire

// File: rtl/rle_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : rle_word_packer
//  Brief    : Expands {value, run} RLE codes one bit per clock into
//             MSB-first words and emits each full or zero-padded final
//             word with a running index.
//  Revision : 1.0  initial release
// ============================================================================
module rle_word_packer
   import rle_pkg::*;
#(
   parameter int WORD_W = rle_pkg::WORD_W,
   parameter int RUN_W  = rle_pkg::RUN_W,
   parameter int IDX_W  = rle_pkg::IDX_W
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   rle_word_packer_if.slave bus
);

   localparam int FILL_W = $clog2(WORD_W + 1);

   state_t              state_q, state_d;
   logic [FILL_W-1:0]   fill_q,  fill_d;
   logic [RUN_W-1:0]    run_q,   run_d;
   logic                val_q,   val_d;
   logic                last_q,  last_d;
   logic [WORD_W-1:0]   word_q,  word_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic                done_q,  done_d;

   code_t               code_fields;
   logic [FILL_W-1:0]   bit_pos;
   logic                code_ready;
   logic                word_valid;
   logic                word_last;

   // Next write position counts down from the MSB as the word fills.
   assign bit_pos     = FILL_W'(WORD_W - 1) - fill_q;
   assign code_fields = rle_unpack(bus.code_in);

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         run_q   <= '0;
         val_q   <= 1'b0;
         last_q  <= 1'b0;
         word_q  <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         run_q   <= run_d;
         val_q   <= val_d;
         last_q  <= last_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      run_d      = run_q;
      val_d      = val_q;
      last_d     = last_q;
      word_d     = word_q;
      idx_d      = idx_q;
      done_d     = 1'b0;
      code_ready = 1'b0;
      word_valid = 1'b0;
      word_last  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Held low while reset is asserted even though state reads IDLE.
            code_ready = rst_n;
            if (bus.code_valid) begin
               val_d  = code_fields.val;
               run_d  = code_fields.run;
               last_d = bus.code_last;
               if (code_fields.run != '0) begin
                  state_d = S_EXPAND;
               end else if (bus.code_last) begin
                  if (fill_q != '0) begin
                     state_d = S_OUT;
                  end else begin
                     // Stream ends on a word boundary: nothing left to emit.
                     done_d = 1'b1;
                     last_d = 1'b0;
                  end
               end
            end
         end

         S_EXPAND: begin
            word_d = word_q | ({{(WORD_W-1){1'b0}}, val_q} << bit_pos);
            fill_d = fill_q + 1'b1;
            run_d  = run_q - 1'b1;
            // A full word must be emitted before the run can continue.
            if (fill_q == FILL_W'(WORD_W - 1)) begin
               state_d = S_OUT;
            end else if (run_q == RUN_W'(1)) begin
               state_d = last_q ? S_OUT : S_IDLE;
            end
         end

         S_OUT: begin
            word_valid = 1'b1;
            word_last  = last_q && (run_q == '0);
            if (bus.word_ready) begin
               idx_d  = idx_q + 1'b1;
               word_d = '0;
               fill_d = '0;
               if (run_q != '0) begin
                  state_d = S_EXPAND;
               end else begin
                  state_d = S_IDLE;
                  if (last_q) begin
                     done_d = 1'b1;
                     last_d = 1'b0;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.code_ready = code_ready;
   assign bus.word_valid = word_valid;
   assign bus.word_out   = word_q;
   assign bus.word_idx   = idx_q;
   assign bus.word_last  = word_last;
   assign bus.bit_idx    = bit_pos[3:0];
   assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_word_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rle_word_packer
//  Brief    : Directed and randomized self-checking bench for the RLE
//             word packer with a bit-queue reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rle_word_packer;
   import rle_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rle_word_packer_if #(.WORD_W(16), .RUN_W(2), .IDX_W(32)) bus ();

   rle_word_packer #(.WORD_W(16), .RUN_W(2), .IDX_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] w;
      logic [31:0] idx;
      logic        last;
   } exp_word_t;

   int          n_chk  = 0;
   int          n_fail = 0;
   int          rdy_mode = 0;     // 0 always ready, 1 random, 2 stalled
   longint      cyc = 0;
   longint      last_hs_cyc = 0;
   bit          pend_done = 1'b0;
   bit          seen_valid = 1'b0;
   int          got_done = 0;
   int          exp_done = 0;
   exp_word_t   exp_q[$];
   bit          bits_q[$];
   logic [31:0] exp_idx = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Reference model: append run bits, cut 16-bit words MSB first, pad on last.
   function automatic void model_code(input logic [2:0] code, input logic last);
      int        run;
      exp_word_t e;
      run = int'(code[1:0]);
      for (int i = 0; i < run; i++) bits_q.push_back(code[2]);
      while (bits_q.size() >= 16) begin
         e.w = '0;
         for (int i = 0; i < 16; i++) e.w[15-i] = bits_q.pop_front();
         e.idx  = exp_idx;
         e.last = last && (bits_q.size() == 0);
         exp_q.push_back(e);
         exp_idx++;
      end
      if (last) begin
         if (bits_q.size() > 0) begin
            e.w = '0;
            for (int i = 0; i < 16; i++) begin
               if (bits_q.size() > 0) e.w[15-i] = bits_q.pop_front();
            end
            e.idx  = exp_idx;
            e.last = 1'b1;
            exp_q.push_back(e);
            exp_idx++;
         end
         exp_done++;
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer ready pattern, changed just after each rising edge.
   initial begin
      bus.word_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.word_ready = 1'b1;
            1:       bus.word_ready = 1'($urandom_range(0, 1));
            default: bus.word_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: every accepted word is compared with the model.
   initial begin
      exp_word_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.word_valid) seen_valid = 1'b1;
            if (bus.word_valid && bus.word_ready) begin
               chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("word_out",  64'(bus.word_out),  64'(e.w));
                  chk("word_idx",  64'(bus.word_idx),  64'(e.idx));
                  chk("word_last", 64'(bus.word_last), 64'(e.last));
               end
               if (bus.word_last) begin
                  last_hs_cyc = cyc;
                  pend_done   = 1'b1;
               end
            end
            if (bus.done) begin
               got_done++;
               if (pend_done) begin
                  chk("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
                  pend_done = 1'b0;
               end
            end
         end
      end
   end

   task automatic send(input logic [2:0] c, input logic l);
      int t;
      t = 0;
      model_code(c, l);
      @(posedge clk);
      #1;
      bus.code_valid = 1'b1;
      bus.code_in    = c;
      bus.code_last  = l;
      @(negedge clk);
      while (!bus.code_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk("send_timeout", 64'(t), 64'd0);
      @(posedge clk);
      #1;
      bus.code_valid = 1'b0;
      bus.code_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (got_done < exp_done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk({tag, "_done_count"}, 64'(got_done), 64'(exp_done));
      chk({tag, "_drained"},    64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int n;
      bus.code_valid = 1'b0;
      bus.code_in    = '0;
      bus.code_last  = 1'b0;

      // Reset held for four clocks.
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_code_ready", 64'(bus.code_ready), 64'd0);
      chk("rst_word_valid", 64'(bus.word_valid), 64'd0);
      chk("rst_word_out",   64'(bus.word_out),   64'd0);
      chk("rst_word_idx",   64'(bus.word_idx),   64'd0);
      chk("rst_word_last",  64'(bus.word_last),  64'd0);
      chk("rst_done",       64'(bus.done),       64'd0);
      chk("rst_bit_idx",    64'(bus.bit_idx),    64'd15);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_code_ready", 64'(bus.code_ready), 64'd1);

      // Sixteen ones form an all-ones word at index 0.
      rdy_mode = 0;
      repeat (5) send(3'b111, 1'b0);
      send(3'b101, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t2_idx_after", 64'(bus.word_idx), 64'd1);
      chk("t2_bit_idx",   64'(bus.bit_idx),  64'd15);

      // Padded final word 0x1C00 with done one cycle after handshake.
      send(3'b011, 1'b0);
      send(3'b110, 1'b0);
      send(3'b101, 1'b1);
      wait_done("t3");

      // Stalled consumer; a 3-bit run straddles the word boundary.
      rdy_mode = 2;
      repeat (4) send(3'b011, 1'b0);
      repeat (2) send(3'b001, 1'b0);
      send(3'b111, 1'b0);
      repeat (2) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_valid_hold", 64'(bus.word_valid), 64'd1);
         chk("t4_word_hold",  64'(bus.word_out),   64'h0003);
         chk("t4_code_block", 64'(bus.code_ready), 64'd0);
      end
      rdy_mode = 0;
      send(3'b000, 1'b1);
      wait_done("t4");

      // Zero-length runs: no state change, then an empty final flush.
      send(3'b100, 1'b0);
      @(negedge clk);
      chk("t5_bit_idx",    64'(bus.bit_idx),    64'd15);
      chk("t5_code_ready", 64'(bus.code_ready), 64'd1);
      seen_valid = 1'b0;
      send(3'b000, 1'b1);
      wait_done("t5");
      chk("t5_no_word", 64'(seen_valid), 64'd0);

      // Reset in the middle of expansion discards the partial word.
      rdy_mode = 2;
      send(3'b111, 1'b0);
      send(3'b111, 1'b0);
      send(3'b111, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_bit_idx_mid", 64'(bus.bit_idx), 64'd8);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_word_out",   64'(bus.word_out),   64'd0);
      chk("t6_rst_word_idx",   64'(bus.word_idx),   64'd0);
      chk("t6_rst_code_ready", 64'(bus.code_ready), 64'd0);
      chk("t6_rst_bit_idx",    64'(bus.bit_idx),    64'd15);
      exp_q.delete();
      bits_q.delete();
      exp_idx   = '0;
      exp_done  = 0;
      got_done  = 0;
      pend_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      rdy_mode = 0;
      send(3'b101, 1'b1);
      wait_done("t6");

      // Randomized streams with random consumer back-pressure.
      for (int s = 0; s < 25; s++) begin
         rdy_mode = int'($urandom_range(0, 1));
         n = int'($urandom_range(1, 10));
         for (int k = 0; k < n; k++) begin
            send(3'($urandom_range(0, 7)), k == n - 1);
         end
         wait_done("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
